e_series_ctrl: RTL

E_SERIES_CTRL -- requirements
Module: e_series_ctrl

---
 rtl/e_series_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/e_series_ctrl.sv
// -----------------------------------------------------------------------------
// e_series_ctrl
//
// Sequencer that evaluates e = 1 + sum(1/k!) for k = 1..N in fixed point,
// using an external divider. Each iteration divides the current term by k,
// then adds the quotient into the running sum. The loop stops at k == N or
// as soon as the term has underflowed to zero.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         begin a computation (accepted only in IDLE)
//   n_terms       highest series index N, latched on an accepted start
//   div_start     one-cycle request pulse to the divider
//   div_dividend  current term, held from ISSUE until WAIT exits
//   div_divisor   current index k, held from ISSUE until WAIT exits
//   div_quotient  divider result
//   div_done      divider result valid (only looked at in WAIT)
//   sum           running / final sum, format 8.FRAC
//   busy          high in every state except IDLE
//   done          one-cycle completion pulse
// -----------------------------------------------------------------------------
module e_series_ctrl #(
   parameter int W    = 400,
   parameter int FRAC = 392
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [7:0]   n_terms,
   output logic         div_start,
   output logic [W-1:0] div_dividend,
   output logic [7:0]   div_divisor,
   input  logic [W-1:0] div_quotient,
   input  logic         div_done,
   output logic [W-1:0] sum,
   output logic         busy,
   output logic         done
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      ACC,
      FINISH
   } state_t;

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1} << FRAC;

   state_t         state;
   state_t         state_nxt;
   logic [W-1:0]   term;
   logic [7:0]     k;
   logic [7:0]     n_lat;
   logic           acc_last;

   // The sum stops growing once the term has underflowed, so there is no
   // point running the divider any further.
   assign acc_last = (term == '0) || (k == n_lat);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: state_nxt gets its default before the case statement, so every
   // path assigns it and no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = (n_terms == 8'd0) ? FINISH : ISSUE;
            end
         end
         ISSUE:  state_nxt = WAIT;
         WAIT: begin
            if (div_done) begin
               state_nxt = ACC;
            end
         end
         ACC:    state_nxt = acc_last ? FINISH : ISSUE;
         FINISH: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath. term and k only change at WAIT exit and in ACC respectively,
   // which keeps the divider operands stable for the whole request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         term  <= '0;
         sum   <= '0;
         k     <= 8'd0;
         n_lat <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  term  <= ONE;
                  sum   <= ONE;
                  k     <= 8'd1;
                  n_lat <= n_terms;
               end
            end
            WAIT: begin
               if (div_done) begin
                  term <= div_quotient;
               end
            end
            ACC: begin
               // Plain modulo-2^W addition; no saturation.
               sum <= sum + term;
               if (!acc_last) begin
                  k <= k + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign div_start    = (state == ISSUE);
   assign div_dividend = term;
   assign div_divisor  = k;
   assign busy         = (state != IDLE);
   assign done         = (state == FINISH);

endmodule
